// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults and helpers for the Tuse/Tnew hazard scoreboard.
// Optional MDU busy tracking is enabled by defining MDU_BUSY_EN.
package hazard_scoreboard_pkg;

    // Default geometry of the scoreboard
    localparam int unsigned DEF_NUM_STAGES = 3;
    localparam int unsigned DEF_REG_AW     = 5;
    localparam int unsigned DEF_TW         = 2;

    // Default MDU busy durations in cycles
    localparam int unsigned DEF_MUL_LAT    = 5;
    localparam int unsigned DEF_DIV_LAT    = 10;

    // All-ones Tuse marks a source operand that the instruction never reads
    function automatic int unsigned tuse_none(input int unsigned tw);
        return (32'd1 << tw) - 32'd1;
    endfunction

    // Width of a forwarding select that can name regfile (0) or slots 1..n
    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage <-> hazard scoreboard bundle: decoded D operands in, stall/forward out.
// The mdu_* fields are only meaningful when MDU_BUSY_EN is defined.
interface hazard_scoreboard_if #(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned TW         = 2
);
    localparam int unsigned SEL_W = (NUM_STAGES < 1) ? 1 : $clog2(NUM_STAGES + 1);

    logic              d_valid;
    logic [REG_AW-1:0] d_rs_addr;
    logic [REG_AW-1:0] d_rt_addr;
    logic [TW-1:0]     d_rs_tuse;
    logic [TW-1:0]     d_rt_tuse;
    logic [REG_AW-1:0] d_dst_addr;
    logic [TW-1:0]     d_tnew;
    logic              d_mdu_start;
    logic              d_mdu_div;
    logic              d_mdu_use;
    logic              stall;
    logic [SEL_W-1:0]  fwd_rs_sel;
    logic [SEL_W-1:0]  fwd_rt_sel;
    logic              mdu_busy;

    // D-stage side
    modport master (
        output d_valid, d_rs_addr, d_rt_addr, d_rs_tuse, d_rt_tuse,
               d_dst_addr, d_tnew, d_mdu_start, d_mdu_div, d_mdu_use,
        input  stall, fwd_rs_sel, fwd_rt_sel, mdu_busy
    );

    // Scoreboard side
    modport slave (
        input  d_valid, d_rs_addr, d_rt_addr, d_rs_tuse, d_rt_tuse,
               d_dst_addr, d_tnew, d_mdu_start, d_mdu_div, d_mdu_use,
        output stall, fwd_rs_sel, fwd_rt_sel, mdu_busy
    );

endinterface

// File: rtl/hazard_scoreboard_mdu_busy_counter.sv
// MDU busy countdown: loads the multiply or divide latency on an accepted
// start and counts down to zero. Only instantiated when MDU_BUSY_EN is defined.
module hazard_scoreboard_mdu_busy_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned MUL_LAT = DEF_MUL_LAT,
    parameter int unsigned DIV_LAT = DEF_DIV_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic is_div,
    output logic busy
);
    localparam int unsigned CW = $clog2(max_u(MUL_LAT, DIV_LAT) + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload on accepted start, otherwise saturating decrement
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard beside the D stage. Tracks in-flight register
// writes across NUM_STAGES slots, raises stall and picks forward sources.
// Define MDU_BUSY_EN to add HI/LO busy tracking for mult/div.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned REG_AW     = DEF_REG_AW,
    parameter int unsigned TW         = DEF_TW,
    parameter int unsigned MUL_LAT    = DEF_MUL_LAT,
    parameter int unsigned DIV_LAT    = DEF_DIV_LAT
) (
    input logic clk,
    input logic reset,
    hazard_scoreboard_if.slave hs
);
    localparam int unsigned SEL_W = sel_width(NUM_STAGES);
    localparam logic [TW-1:0] TUSE_NONE = TW'(tuse_none(TW));

    // Array index i holds pipeline slot i+1 (index 0 is E)
    logic              slot_vld  [NUM_STAGES];
    logic [REG_AW-1:0] slot_dst  [NUM_STAGES];
    logic [TW-1:0]     slot_tnew [NUM_STAGES];

    logic [NUM_STAGES-1:0] rs_hit;
    logic [NUM_STAGES-1:0] rt_hit;

    logic             rs_found, rt_found;
    logic [SEL_W-1:0] rs_idx, rt_idx;
    logic [TW-1:0]    rs_tnew, rt_tnew;
    logic             rs_active, rt_active;
    logic             rs_hazard, rt_hazard;
    logic             mdu_hazard;
    logic             stall;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? t : t - TW'(1);
    endfunction

    // Slot shift chain: D enters slot 1 (or a bubble on stall), older entries age
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                slot_vld[i]  <= 1'b0;
                slot_dst[i]  <= '0;
                slot_tnew[i] <= '0;
            end
        end else begin
            slot_vld[0]  <= !stall && hs.d_valid && (hs.d_dst_addr != '0);
            slot_dst[0]  <= stall ? '0 : hs.d_dst_addr;
            slot_tnew[0] <= stall ? '0 : hs.d_tnew;
            for (int i = 1; i < NUM_STAGES; i++) begin
                slot_vld[i]  <= slot_vld[i-1];
                slot_dst[i]  <= slot_dst[i-1];
                slot_tnew[i] <= sat_dec(slot_tnew[i-1]);
            end
        end
    end

    // Per-slot address comparators for both sources
    for (genvar g = 0; g < NUM_STAGES; g++) begin : gen_match
        assign rs_hit[g] = slot_vld[g] && (slot_dst[g] == hs.d_rs_addr);
        assign rt_hit[g] = slot_vld[g] && (slot_dst[g] == hs.d_rt_addr);
    end

    // Priority encode: scan oldest to newest so the nearest slot wins
    always_comb begin
        rs_found = 1'b0;
        rs_idx   = '0;
        rs_tnew  = '0;
        rt_found = 1'b0;
        rt_idx   = '0;
        rt_tnew  = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (rs_hit[i]) begin
                rs_found = 1'b1;
                rs_idx   = SEL_W'(i + 1);
                rs_tnew  = slot_tnew[i];
            end
            if (rt_hit[i]) begin
                rt_found = 1'b1;
                rt_idx   = SEL_W'(i + 1);
                rt_tnew  = slot_tnew[i];
            end
        end
    end

    // Hazard and forward decisions per source
    always_comb begin
        rs_active = (hs.d_rs_tuse != TUSE_NONE) && (hs.d_rs_addr != '0);
        rt_active = (hs.d_rt_tuse != TUSE_NONE) && (hs.d_rt_addr != '0);
        rs_hazard = rs_active && rs_found && (rs_tnew > hs.d_rs_tuse);
        rt_hazard = rt_active && rt_found && (rt_tnew > hs.d_rt_tuse);
        hs.fwd_rs_sel = (rs_active && rs_found && (rs_tnew == '0)) ? rs_idx : '0;
        hs.fwd_rt_sel = (rt_active && rt_found && (rt_tnew == '0)) ? rt_idx : '0;
    end

`ifdef MDU_BUSY_EN
    logic mdu_load;
    logic mdu_busy_int;

    // A start that itself stalls (MDU still busy) must not reload the count
    assign mdu_load = hs.d_valid && hs.d_mdu_start && !stall;

    hazard_scoreboard_mdu_busy_counter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .load   (mdu_load),
        .is_div (hs.d_mdu_div),
        .busy   (mdu_busy_int)
    );

    assign mdu_hazard  = (hs.d_mdu_start || hs.d_mdu_use) && mdu_busy_int;
    assign hs.mdu_busy = mdu_busy_int;
`else
    logic unused_mdu;

    assign unused_mdu  = ^{hs.d_mdu_start, hs.d_mdu_div, hs.d_mdu_use};
    assign mdu_hazard  = 1'b0;
    assign hs.mdu_busy = 1'b0;
`endif

    assign stall    = hs.d_valid && (rs_hazard || rt_hazard || mdu_hazard);
    assign hs.stall = stall;

endmodule
